// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO driving the register-file write port, with forwarding.
// Define WB_STATS_EN to add the wb_retired / wb_dropped counters.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

module wb_queue #(
    parameter int DEPTH = 2,
    parameter int GPR_W = `GPR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [GPR_W-1:0] in_data,
    input  logic             in_ctrl,
    input  logic             in_partial,
    input  logic             in_nowrite,
    input  logic             hold,
    output logic             rf_en,
    output logic             rf_ctrl,
    output logic [4:0]       rf_rd,
    output logic [GPR_W-1:0] rf_data,
    input  logic [4:0]       fwd_rs_addr,
    input  logic [4:0]       fwd_rt_addr,
    output logic             fwd_rs_hit,
    output logic [GPR_W-1:0] fwd_rs_data,
    output logic             fwd_rs_stall,
    output logic             fwd_rt_hit,
    output logic [GPR_W-1:0] fwd_rt_data,
    output logic             fwd_rt_stall,
    output logic             empty
`ifdef WB_STATS_EN
    ,
    output logic [31:0]      wb_retired,
    output logic [31:0]      wb_dropped
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]       rd;
        logic [GPR_W-1:0] data;
        logic             ctrl;
        logic             partial;
        logic             nowrite;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic             busy;
    logic             push;
    logic             pop;
    entry_t           hd;

    // Ready is a function of occupancy only, so no combinational path from hold.
    assign busy     = (count != '0);
    assign in_ready = (count != FULL);
    assign empty    = ~busy;
    assign push     = in_valid & in_ready;
    assign pop      = busy & ~hold;
    assign hd       = mem[head];

    assign rf_en   = pop & ~hd.nowrite & ~hd.rd[4];
    assign rf_ctrl = busy & hd.ctrl;
    assign rf_rd   = busy ? hd.rd : '0;
    assign rf_data = busy ? hd.data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                tail      <= tail + 1'b1;
                vld[tail] <= 1'b1;
            end
            if (pop) begin
                head      <= head + 1'b1;
                vld[head] <= 1'b0;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= entry_t'{in_rd, in_data, in_ctrl, in_partial, in_nowrite};
        end
    end

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [AW-1:0] idx;
        entry_t        e;
        idx          = '0;
        e            = '0;
        fwd_rs_hit   = 1'b0;
        fwd_rs_data  = '0;
        fwd_rs_stall = 1'b0;
        fwd_rt_hit   = 1'b0;
        fwd_rt_data  = '0;
        fwd_rt_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + i[AW-1:0];
            e   = mem[idx];
            if (vld[idx] && !e.nowrite && !e.rd[4]) begin
                if (e.rd == fwd_rs_addr) begin
                    fwd_rs_hit   = 1'b1;
                    fwd_rs_data  = e.data;
                    fwd_rs_stall = e.partial;
                end
                if (e.rd == fwd_rt_addr) begin
                    fwd_rt_hit   = 1'b1;
                    fwd_rt_data  = e.data;
                    fwd_rt_stall = e.partial;
                end
            end
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_retired <= '0;
            wb_dropped <= '0;
        end else if (pop) begin
            if (rf_en) begin
                wb_retired <= wb_retired + 32'd1;
            end else begin
                wb_dropped <= wb_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized + directed bench for wb_queue with a queue-based reference model
// and a scoreboard monitor that checks every register-file write.
module tb_wb_queue;

    localparam int DEPTH = 2;
    localparam int W     = 32;

    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] data;
        logic         ctrl;
        logic         partial;
        logic         nowrite;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_rd;
    logic [W-1:0] in_data;
    logic         in_ctrl;
    logic         in_partial;
    logic         in_nowrite;
    logic         hold;
    logic         rf_en;
    logic         rf_ctrl;
    logic [4:0]   rf_rd;
    logic [W-1:0] rf_data;
    logic [4:0]   fwd_rs_addr;
    logic [4:0]   fwd_rt_addr;
    logic         fwd_rs_hit;
    logic [W-1:0] fwd_rs_data;
    logic         fwd_rs_stall;
    logic         fwd_rt_hit;
    logic [W-1:0] fwd_rt_data;
    logic         fwd_rt_stall;
    logic         empty;
`ifdef WB_STATS_EN
    logic [31:0]  wb_retired;
    logic [31:0]  wb_dropped;
    logic [31:0]  m_ret;
    logic [31:0]  m_drop;
`endif

    int   checks  = 0;
    int   errors  = 0;
    bit   started = 0;
    ent_t mq[$];
    ent_t sb[$];

    wb_queue #(.DEPTH(DEPTH), .GPR_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_partial   (in_partial),
        .in_nowrite   (in_nowrite),
        .hold         (hold),
        .rf_en        (rf_en),
        .rf_ctrl      (rf_ctrl),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .fwd_rs_addr  (fwd_rs_addr),
        .fwd_rt_addr  (fwd_rt_addr),
        .fwd_rs_hit   (fwd_rs_hit),
        .fwd_rs_data  (fwd_rs_data),
        .fwd_rs_stall (fwd_rs_stall),
        .fwd_rt_hit   (fwd_rt_hit),
        .fwd_rt_data  (fwd_rt_data),
        .fwd_rt_stall (fwd_rt_stall),
        .empty        (empty)
`ifdef WB_STATS_EN
        ,
        .wb_retired   (wb_retired),
        .wb_dropped   (wb_dropped)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Youngest queued entry that will really write this register.
    function automatic void lookup(input logic [4:0] a, output logic hit,
                                   output logic [W-1:0] d, output logic st);
        hit = 1'b0;
        d   = '0;
        st  = 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!mq[i].nowrite && mq[i].rd == a && mq[i].rd < 16) begin
                hit = 1'b1;
                d   = mq[i].data;
                st  = mq[i].partial;
                break;
            end
        end
    endfunction

    task automatic check_outputs();
        ent_t         h;
        logic         en;
        logic         hit;
        logic [W-1:0] d;
        logic         st;
        h.rd = '0; h.data = '0; h.ctrl = 1'b0; h.partial = 1'b0; h.nowrite = 1'b1;
        if (mq.size() > 0) h = mq[0];
        en = (mq.size() > 0) && !hold && !h.nowrite && (h.rd < 16);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("rf_en", rf_en, en);
        chk("rf_rd", rf_rd, h.rd);
        chk("rf_data", rf_data, h.data);
        chk("rf_ctrl", rf_ctrl, h.ctrl);
        lookup(fwd_rs_addr, hit, d, st);
        chk("fwd_rs_hit", fwd_rs_hit, hit);
        chk("fwd_rs_data", fwd_rs_data, d);
        chk("fwd_rs_stall", fwd_rs_stall, st);
        lookup(fwd_rt_addr, hit, d, st);
        chk("fwd_rt_hit", fwd_rt_hit, hit);
        chk("fwd_rt_data", fwd_rt_data, d);
        chk("fwd_rt_stall", fwd_rt_stall, st);
`ifdef WB_STATS_EN
        chk("wb_retired", wb_retired, m_ret);
        chk("wb_dropped", wb_dropped, m_drop);
`endif
    endtask

    // Advance the model across one clock edge using the inputs held during the cycle.
    task automatic model_update();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (rst) begin
            mq.delete();
            sb.delete();
`ifdef WB_STATS_EN
            m_ret  = '0;
            m_drop = '0;
`endif
            return;
        end
        do_pop  = (mq.size() > 0) && !hold;
        do_push = in_valid && (mq.size() < DEPTH);
        if (do_pop) begin
            e = mq.pop_front();
`ifdef WB_STATS_EN
            if (!e.nowrite && e.rd < 16) m_ret = m_ret + 1;
            else m_drop = m_drop + 1;
`endif
        end
        if (do_push) begin
            e.rd      = in_rd;
            e.data    = in_data;
            e.ctrl    = in_ctrl;
            e.partial = in_partial;
            e.nowrite = in_nowrite;
            mq.push_back(e);
            if (!e.nowrite && e.rd < 16) sb.push_back(e);
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [W-1:0] d,
                         input logic p, input logic nw, input logic h);
        in_valid   = v;
        in_rd      = rd;
        in_data    = d;
        in_ctrl    = d[0];
        in_partial = p;
        in_nowrite = nw;
        hold       = h;
    endtask

    // Scoreboard monitor: every observed write must match the next expected write.
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (started && rf_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: rd=%0d data=%0h, expected no write", rf_rd, rf_data);
            end else begin
                e = sb.pop_front();
                chk("wr_rd", rf_rd, e.rd);
                chk("wr_data", rf_data, e.data);
                chk("wr_ctrl", rf_ctrl, e.ctrl);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        fwd_rs_addr = '0;
        fwd_rt_addr = '0;
`ifdef WB_STATS_EN
        m_ret  = '0;
        m_drop = '0;
`endif
        @(negedge clk);
        started = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_fwd_hit", fwd_rs_hit, 0);
        cycle();
        rst = 1'b0;

        // Single write with one-cycle latency
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_rf_en", rf_en, 1);
        chk("t1_rf_rd", rf_rd, 3);
        chk("t1_rf_data", rf_data, 32'hDEADBEEF);
        cycle();
        #1;
        chk("t1_empty", empty, 1);
        cycle();

        // Fill under hold, then drain in order
        drive(1, 1, 32'h11, 0, 0, 1);
        cycle();
        drive(1, 2, 32'h22, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("t2_full_ready", in_ready, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_w1_en", rf_en, 1);
        chk("t2_w1_data", rf_data, 32'h11);
        cycle();
        #1;
        chk("t2_w2_en", rf_en, 1);
        chk("t2_w2_data", rf_data, 32'h22);
        cycle();

        // Youngest match wins
        drive(1, 5, 32'hA, 0, 0, 1);
        cycle();
        drive(1, 5, 32'hB, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        fwd_rs_addr = 5;
        #1;
        chk("t3_hit", fwd_rs_hit, 1);
        chk("t3_data", fwd_rs_data, 32'hB);
        chk("t3_stall", fwd_rs_stall, 0);
        cycle();
        hold = 1'b0;
        cycle();
        cycle();

        // Partial forces stall; nowrite never forwards
        drive(1, 7, 32'h77, 1, 0, 1);
        fwd_rt_addr = 7;
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("t4_hit", fwd_rt_hit, 1);
        chk("t4_stall", fwd_rt_stall, 1);
        cycle();
        hold = 1'b0;
        cycle();
        drive(1, 7, 32'h78, 0, 1, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("t4_nowrite_hit", fwd_rt_hit, 0);
        cycle();
        hold = 1'b0;
        cycle();

        // rd >= 16 pops without writing
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1, 20, 32'h2020, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_rf_en", rf_en, 0);
        chk("t5_rf_rd", rf_rd, 20);
        cycle();
        #1;
        chk("t5_empty", empty, 1);
`ifdef WB_STATS_EN
        chk("t5_dropped", wb_dropped, 1);
        chk("t5_retired", wb_retired, 0);
`endif
        cycle();

        // Reset while full discards everything
        drive(1, 9, 32'h99, 0, 0, 1);
        cycle();
        drive(1, 10, 32'hAA, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        hold = 1'b0;
        #1;
        chk("t6_empty", empty, 1);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_rf_en", rf_en, 0);
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_rd       = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, 31));
            in_data     = $urandom;
            in_ctrl     = 1'($urandom_range(0, 1));
            in_partial  = ($urandom_range(0, 4) == 0);
            in_nowrite  = ($urandom_range(0, 6) == 0);
            hold        = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            fwd_rs_addr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, 31));
            fwd_rt_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        // Drain and confirm every expected write happened
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 3; i++) cycle();
        #3;
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
